// File: rtl/led_mode_if.sv
// Key/LED bundle between the debouncer-side logic and led_mode_ctrl.
// The master drives the debounced keys; the slave drives the LED bank and status.
interface led_mode_if;
  logic [2:0] key_in;
  logic [3:0] led;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       running;

  modport master (
    output key_in,
    input  led,
    input  mode,
    input  speed,
    input  running
  );

  modport slave (
    input  key_in,
    output led,
    output mode,
    output speed,
    output running
  );
endinterface

// File: rtl/led_mode_ctrl.sv
// Mode/speed/run controller for the 4-LED bank.
// key0 cycles mode, key1 cycles speed, key2 toggles pause; a prescaler steps patterns.
module led_mode_ctrl #(
  parameter int BASE_TICK = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  led_mode_if.slave  bus
);

  localparam int CNT_W = $clog2(BASE_TICK);

  localparam logic [CNT_W-1:0] LAST0 =
    CNT_W'(BASE_TICK - 1);
  localparam logic [CNT_W-1:0] LAST1 =
    CNT_W'((BASE_TICK >> 1) - 1);
  localparam logic [CNT_W-1:0] LAST2 =
    CNT_W'((BASE_TICK >> 2) - 1);
  localparam logic [CNT_W-1:0] LAST3 =
    CNT_W'((BASE_TICK >> 3) - 1);

  typedef enum logic [1:0] {
    ALL_ON = 2'd0,
    FLOW_L = 2'd1,
    FLOW_R = 2'd2,
    BLINK  = 2'd3
  } mode_e;

  mode_e            mode_q, mode_d;
  logic [1:0]       speed_q, speed_d;
  logic             run_q, run_d;
  logic [3:0]       led_q, led_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       key_prev;

  logic [2:0]       evt;
  logic             clr;
  logic             tick;
  logic [CNT_W-1:0] p_last;

  assign evt = bus.key_in & ~key_prev;
  assign clr = evt[0] | evt[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= ALL_ON;
      speed_q  <= 2'd0;
      run_q    <= 1'b1;
      led_q    <= 4'b1111;
      cnt_q    <= '0;
      key_prev <= 3'b000;
    end else begin
      mode_q   <= mode_d;
      speed_q  <= speed_d;
      run_q    <= run_d;
      led_q    <= led_d;
      cnt_q    <= cnt_d;
      key_prev <= bus.key_in;
    end
  end

  always_comb begin
    p_last = LAST0;
    unique case (speed_q)
      2'd0: p_last = LAST0;
      2'd1: p_last = LAST1;
      2'd2: p_last = LAST2;
      2'd3: p_last = LAST3;
    endcase
  end

  // A clearing key event wins over a tick landing in the same cycle.
  assign tick = run_q & ~clr & (cnt_q == p_last);

  always_comb begin
    mode_d  = mode_q;
    speed_d = speed_q;
    run_d   = run_q ^ evt[2];
    led_d   = led_q;
    cnt_d   = cnt_q;

    if (evt[0])
      mode_d = mode_e'(mode_q + 2'd1);
    if (evt[1])
      speed_d = speed_q + 2'd1;

    if (clr)
      cnt_d = '0;
    else if (tick)
      cnt_d = '0;
    else if (run_q)
      cnt_d = cnt_q + 1'b1;

    if (evt[0]) begin
      unique case (mode_d)
        ALL_ON: led_d = 4'b1111;
        FLOW_L: led_d = 4'b0001;
        FLOW_R: led_d = 4'b1000;
        BLINK:  led_d = 4'b1111;
      endcase
    end else if (tick) begin
      unique case (mode_q)
        ALL_ON: led_d = led_q;
        FLOW_L: led_d = {led_q[2:0], led_q[3]};
        FLOW_R: led_d = {led_q[0], led_q[3:1]};
        BLINK:  led_d = ~led_q;
      endcase
    end
  end

  assign bus.led     = led_q;
  assign bus.mode    = mode_q;
  assign bus.speed   = speed_q;
  assign bus.running = run_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl with BASE_TICK=8.
// Stimulus queues expected outputs per cycle; a monitor checks them on negedge.
module tb_led_mode_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nvec = 0;
  int   nmis = 0;

  typedef struct {
    int         at;
    string      nm;
    logic [8:0] v;
  } exp_t;

  exp_t q[$];

  led_mode_if bus ();

  led_mode_ctrl #(.BASE_TICK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [8:0] got;
    exp_t e;
    got = {bus.led, bus.mode, bus.speed, bus.running};
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      nvec++;
      if (e.at < cyc) begin
        nmis++;
        $display("FAIL %s: not checked at cycle %0d",
                 e.nm, e.at);
      end else if (got !== e.v) begin
        nmis++;
        $display("FAIL %s @%0d: got led=%b m=%0d s=%0d r=%b, exp led=%b m=%0d s=%0d r=%b",
                 e.nm, cyc, got[8:5], got[4:3], got[2:1],
                 got[0], e.v[8:5], e.v[4:3], e.v[2:1],
                 e.v[0]);
      end
    end
  end

  function automatic void chk(int at, string nm,
                              logic [3:0] l, logic [1:0] m,
                              logic [1:0] s, logic r);
    exp_t e;
    e.at = at;
    e.nm = nm;
    e.v  = {l, m, s, r};
    q.push_back(e);
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(int i);
    bus.key_in[i] = 1'b1;
    step(1);
    bus.key_in[i] = 1'b0;
    step(1);
  endtask

  initial begin
    int c;
    bus.key_in = 3'b000;

    // reset
    step(2);
    c = cyc;
    chk(c,      "rst",     4'b1111, 0, 0, 1);
    chk(c + 10, "rst_10",  4'b1111, 0, 0, 1);
    chk(c + 20, "rst_20",  4'b1111, 0, 0, 1);
    chk(c + 40, "rst_40",  4'b1111, 0, 0, 1);
    rst = 1'b0;
    step(41);

    // FLOW_L entry with held key, then rotation
    c = cyc;
    chk(c + 1,  "fl_entry", 4'b0001, 1, 0, 1);
    chk(c + 8,  "fl_pre",   4'b0001, 1, 0, 1);
    chk(c + 9,  "fl_s1",    4'b0010, 1, 0, 1);
    chk(c + 17, "fl_s2",    4'b0100, 1, 0, 1);
    chk(c + 20, "fl_held",  4'b0100, 1, 0, 1);
    chk(c + 25, "fl_s3",    4'b1000, 1, 0, 1);
    chk(c + 33, "fl_wrap",  4'b0001, 1, 0, 1);
    bus.key_in[0] = 1'b1;
    step(20);
    bus.key_in[0] = 1'b0;
    step(14);

    // FLOW_R
    c = cyc;
    chk(c + 1,  "fr_entry", 4'b1000, 2, 0, 1);
    chk(c + 9,  "fr_s1",    4'b0100, 2, 0, 1);
    bus.key_in[0] = 1'b1;
    step(2);
    bus.key_in[0] = 1'b0;
    step(8);

    // BLINK speed stepping
    c = cyc;
    chk(c + 1,  "bl_entry", 4'b1111, 3, 0, 1);
    chk(c + 7,  "sp3",      4'b1111, 3, 3, 1);
    chk(c + 8,  "sp3_t1",   4'b0000, 3, 3, 1);
    chk(c + 9,  "sp3_t2",   4'b1111, 3, 3, 1);
    chk(c + 10, "sp3_t3",   4'b0000, 3, 3, 1);
    chk(c + 11, "sp3_t4",   4'b1111, 3, 3, 1);
    chk(c + 12, "sp3_t5",   4'b0000, 3, 3, 1);
    chk(c + 13, "sp_wrap",  4'b0000, 3, 0, 1);
    chk(c + 20, "sp0_pre",  4'b0000, 3, 0, 1);
    chk(c + 21, "sp0_tick", 4'b1111, 3, 0, 1);
    pulse(0);
    pulse(1);
    pulse(1);
    pulse(1);
    step(4);
    pulse(1);
    step(8);

    // pause / resume in FLOW_L
    c = cyc;
    chk(c + 1,  "m_wrap0",  4'b1111, 0, 0, 1);
    chk(c + 3,  "p_entry",  4'b0001, 1, 0, 1);
    chk(c + 9,  "paused",   4'b0001, 1, 0, 0);
    chk(c + 30, "frozen30", 4'b0001, 1, 0, 0);
    chk(c + 59, "frozen59", 4'b0001, 1, 0, 0);
    chk(c + 61, "resumed",  4'b0001, 1, 0, 1);
    chk(c + 62, "res_pre",  4'b0001, 1, 0, 1);
    chk(c + 63, "res_step", 4'b0010, 1, 0, 1);
    chk(c + 70, "res_pre2", 4'b0010, 1, 0, 1);
    chk(c + 71, "res_st2",  4'b0100, 1, 0, 1);
    pulse(0);
    pulse(0);
    step(4);
    pulse(2);
    step(50);
    pulse(2);
    step(10);

    // simultaneous mode+speed at cnt == P-1
    c = cyc;
    chk(c + 6,  "sim_pre",  4'b0100, 1, 0, 1);
    chk(c + 7,  "sim_evt",  4'b1000, 2, 1, 1);
    chk(c + 10, "sim_hold", 4'b1000, 2, 1, 1);
    chk(c + 11, "sim_tick", 4'b0100, 2, 1, 1);
    step(6);
    bus.key_in = 3'b011;
    step(1);
    bus.key_in = 3'b000;
    step(5);

    // reset while paused, with a key rise in the same cycle
    c = cyc;
    chk(c + 6, "pre_rst",  4'b0000, 3, 2, 0);
    chk(c + 7, "mid_rst",  4'b1111, 0, 0, 1);
    chk(c + 8, "post_rst", 4'b1111, 0, 0, 1);
    pulse(0);
    pulse(1);
    pulse(2);
    rst = 1'b1;
    bus.key_in = 3'b001;
    step(1);
    rst = 1'b0;
    bus.key_in = 3'b000;
    step(1);

    for (int i = 0; i < 200 && q.size() > 0; i++)
      step(1);
    if (q.size() > 0) begin
      nmis++;
      $display("FAIL drain: %0d checks pending, exp 0",
               q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
